tdm_mux_4ch: RTL and testbench

- Time-division multiplexer: the collecting end of the team's 1x4 demux-based distribution path.
- Captures NCH parallel channel words on a load strobe.
- Emits them one per beat on a single serial output, with channel select and frame markers.
- Downstream is a 1xNCH demux consumer, which may stall the stream through out_ready.

---
 rtl/tdm_mux_4ch_pkg.sv | 13 +
 rtl/tdm_ch_counter.sv | 27 ++
 rtl/tdm_mux_4ch.sv | 113 +++++++++++
 tb/tb_tdm_mux_4ch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_4ch_pkg.sv
// Shared definitions for the TDM multiplexer slice: FSM state encoding and
// default frame geometry.
package tdm_mux_4ch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;

endpackage

// File: rtl/tdm_ch_counter.sv
// Channel index counter for the TDM multiplexer; terminal count marks the
// last beat of a frame.
module tdm_ch_counter #(
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [SELW-1:0] cnt,
    output logic            tc
);

    // Clear has priority so a new frame always restarts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + SELW'(1);
        end
    end

    assign tc = (cnt == {SELW{1'b1}});

endmodule

// File: rtl/tdm_mux_4ch.sv
// Time-division multiplexer: captures NCH channel words on load and emits
// them one beat at a time with select and frame markers.
module tdm_mux_4ch
    import tdm_mux_4ch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NCH*WIDTH-1:0] ch_in,
    output logic               load_ready,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               frame_start,
    output logic               frame_done
);

    state_t           state;
    state_t           state_nxt;
    logic             xfer;
    logic             last_beat;
    logic             last_xfer;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic [SELW-1:0]  sel_next;
    logic [WIDTH-1:0] shadow [NCH];

    assign out_valid  = (state == ST_SEND);
    assign busy       = (state == ST_SEND);
    assign xfer       = out_valid && out_ready;
    assign last_xfer  = xfer && last_beat;
    // Accepting on the last-beat transfer lets frames run back to back.
    assign load_ready = (state == ST_IDLE) || last_xfer;
    assign accept     = load && load_ready;
    assign cnt_clr    = accept || last_xfer;
    assign cnt_en     = xfer && !last_beat;
    assign sel_next   = out_sel + SELW'(1);

    tdm_ch_counter #(
        .SELW (SELW)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (out_sel),
        .tc  (last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SEND;
            ST_SEND: begin
                if (accept) begin
                    state_nxt = ST_SEND;
                end else if (last_xfer) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                shadow[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NCH; k++) begin
                shadow[k] <= ch_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Beat 0 comes straight from ch_in because the shadow copy lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= last_xfer;
            if (accept) begin
                out_data    <= ch_in[WIDTH-1:0];
                frame_start <= 1'b1;
            end else if (last_xfer) begin
                out_data    <= '0;
                frame_start <= 1'b0;
            end else if (xfer) begin
                out_data    <= shadow[sel_next];
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_4ch.sv
// Self-checking bench for tdm_mux_4ch: directed frame scenarios plus random
// load/backpressure traffic compared against a frame-level reference model.
module tb_tdm_mux_4ch;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load;
    logic [NCH*WIDTH-1:0] ch_in;
    logic                 load_ready;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 frame_start;
    logic                 frame_done;

    int tests = 0;
    int fails = 0;

    // Reference model: the captured frame, which beat is on the wire, and
    // whether the previous cycle completed a frame.
    logic [WIDTH-1:0] m_frame [NCH];
    bit               m_active;
    int               m_idx;
    bit               m_done;

    localparam logic [31:0] FRAME_A = 32'h44332211;
    localparam logic [31:0] FRAME_B = 32'hDDCCBBAA;

    tdm_mux_4ch #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .ch_in       (ch_in),
        .load_ready  (load_ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic [31:0] exp_data;
        exp_data = m_active ? 32'(m_frame[m_idx]) : 32'h0;
        checkOutput("out_valid",   32'(out_valid),   32'(m_active));
        checkOutput("busy",        32'(busy),        32'(m_active));
        checkOutput("out_data",    32'(out_data),    exp_data);
        checkOutput("out_sel",     32'(out_sel),     m_active ? 32'(m_idx) : 32'h0);
        checkOutput("frame_start", 32'(frame_start), 32'(m_active && m_idx == 0));
        checkOutput("frame_done",  32'(frame_done),  32'(m_done));
        checkOutput("load_ready",  32'(load_ready),
                    32'(!m_active || (out_ready && m_idx == NCH-1)));
    endtask

    task automatic modelStep(input bit ld, input bit rdy, input logic [31:0] ch);
        bit last_x;
        bit acc;
        last_x = m_active && rdy && (m_idx == NCH-1);
        acc    = ld && (!m_active || last_x);
        m_done = last_x;
        if (acc) begin
            for (int k = 0; k < NCH; k++) m_frame[k] = ch[k*WIDTH +: WIDTH];
            m_active = 1'b1;
            m_idx    = 0;
        end else if (m_active && rdy) begin
            if (m_idx == NCH-1) m_active = 1'b0;
            else                m_idx++;
        end
    endtask

    // One clock cycle: drive inputs, check everything mid-cycle, then advance the model.
    task automatic applyStimulus(input bit ld, input bit rdy, input logic [31:0] ch);
        @(negedge clk);
        load      = ld;
        out_ready = rdy;
        ch_in     = ch;
        #1;
        checkAll();
        @(posedge clk);
        modelStep(ld, rdy, ch);
    endtask

    task automatic midReset();
        @(negedge clk);
        load = 1'b0;
        #2;
        rst = 1'b1;
        m_active = 1'b0;
        m_idx    = 0;
        m_done   = 1'b0;
        #1;
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        out_ready = 1'b1;
        ch_in     = '0;
        m_active  = 1'b0;
        m_idx     = 0;
        m_done    = 1'b0;
        for (int k = 0; k < NCH; k++) m_frame[k] = '0;
        #1;
        checkAll();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single frame with free-flowing output
        applyStimulus(1'b1, 1'b1, FRAME_A);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, FRAME_A);

        // Three stall cycles on beat 2
        applyStimulus(1'b1, 1'b1, FRAME_A);
        applyStimulus(1'b0, 1'b1, FRAME_A);
        applyStimulus(1'b0, 1'b1, FRAME_A);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, FRAME_A);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, FRAME_A);

        // Back-to-back frames: load on the last-beat transfer edge
        applyStimulus(1'b1, 1'b1, FRAME_A);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, FRAME_A);
        applyStimulus(1'b1, 1'b1, FRAME_B);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, FRAME_B);

        // Load during beat 1 must be ignored
        applyStimulus(1'b1, 1'b1, FRAME_A);
        applyStimulus(1'b0, 1'b1, FRAME_A);
        applyStimulus(1'b1, 1'b1, FRAME_B);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, FRAME_B);

        // ch_in churns every cycle during the frame
        applyStimulus(1'b1, 1'b1, FRAME_A);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, $urandom());

        // Asynchronous reset during beat 2, then a clean restart
        applyStimulus(1'b1, 1'b1, FRAME_A);
        applyStimulus(1'b0, 1'b1, FRAME_A);
        applyStimulus(1'b0, 1'b1, FRAME_A);
        midReset();
        applyStimulus(1'b0, 1'b1, FRAME_A);
        applyStimulus(1'b1, 1'b1, FRAME_B);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, FRAME_B);

        // Random loads and backpressure
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom() % 4) == 0, ($urandom() % 4) != 0, $urandom());
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
